// File: rtl/bus_activity_monitor_pkg.sv
// Shared definitions for the bus activity monitor: FSM state encoding,
// watchdog/beat counter widths and a saturating beat increment helper.
package bus_activity_monitor_pkg;

    localparam int unsigned WD_WIDTH   = 16;
    localparam int unsigned BEAT_WIDTH = 9;
    localparam logic [BEAT_WIDTH-1:0] BEAT_MAX = 9'd511;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACTIVE   = 2'd1,
        ST_ERR_WAIT = 2'd2
    } bus_state_e;

    function automatic logic [BEAT_WIDTH-1:0] sat_inc(
        input logic [BEAT_WIDTH-1:0] v
    );
        return (v == BEAT_MAX) ? v : v + BEAT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Inactivity watchdog: counts enabled cycles, clears on clear_i.
// Ports: clk_i, rst_i (sync, high), clear_i, enable_i, expired_o.
module bus_watchdog
    import bus_activity_monitor_pkg::*;
#(
    parameter int unsigned THRESHOLD = 1023
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [WD_WIDTH-1:0] THR = WD_WIDTH'(THRESHOLD);

    logic [WD_WIDTH-1:0] cnt_q;
    logic [WD_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + WD_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = enable_i && (cnt_q == THR);

endmodule

// File: rtl/bus_activity_monitor.sv
// Bus transaction monitor: tracks open transactions, counts beats,
// flags beat-count mismatch, bus errors, inactivity timeouts and
// protocol violations (sticky, cleared by clearErrors).
// Inputs: clock, reset, begin/end/dataValid/busError strobes,
//   burstSizeIn (beats-1), clearErrors.
// Outputs: busIdle, transactionDone, beatCount, four sticky flags.
module bus_activity_monitor
    import bus_activity_monitor_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       beginTransactionIn,
    input  logic       endTransactionIn,
    input  logic       dataValidIn,
    input  logic       busErrorIn,
    input  logic [7:0] burstSizeIn,
    input  logic       clearErrors,
    output logic       busIdle,
    output logic       transactionDone,
    output logic [8:0] beatCount,
    output logic       beatMismatch,
    output logic       busErrorSeen,
    output logic       timeoutError,
    output logic       protocolError
);

    bus_state_e state_q, state_d;
    logic [7:0] burst_q, burst_d;
    logic [8:0] beat_q, beat_d;
    logic       idle_q, done_q, done_d;
    logic       mm_q, be_q, to_q, pe_q;
    logic       set_mm, set_be, set_to, set_pe;
    logic       wd_expired;
    logic       timeout;

    // Counts quiet cycles while a transaction is open; a beat restarts it.
    bus_watchdog #(
        .THRESHOLD(TIMEOUT_CYCLES - 1)
    ) u_wd (
        .clk_i    (clock),
        .rst_i    (reset),
        .clear_i  ((state_q == ST_IDLE) || dataValidIn),
        .enable_i (state_q != ST_IDLE),
        .expired_o(wd_expired)
    );

    // A beat or an end in the threshold cycle both rescue the transaction.
    assign timeout = wd_expired && !dataValidIn && !endTransactionIn;

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        beat_d  = beat_q;
        done_d  = 1'b0;
        set_mm  = 1'b0;
        set_be  = 1'b0;
        set_to  = 1'b0;
        set_pe  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (beginTransactionIn && !endTransactionIn) begin
                    state_d = ST_ACTIVE;
                    burst_d = burstSizeIn;
                    beat_d  = '0;
                end else if (beginTransactionIn) begin
                    // zero-length transaction
                    done_d = 1'b1;
                    set_mm = 1'b1;
                    beat_d = '0;
                end else if (dataValidIn || endTransactionIn) begin
                    set_pe = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (beginTransactionIn && !endTransactionIn) begin
                    set_pe  = 1'b1;
                    burst_d = burstSizeIn;
                    beat_d  = {8'd0, dataValidIn};
                end else if (dataValidIn) begin
                    beat_d = sat_inc(beat_q);
                end
                if (endTransactionIn) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    set_be  = busErrorIn;
                    set_mm  = (beat_d != ({1'b0, burst_q} + 9'd1));
                end else if (timeout) begin
                    state_d = ST_IDLE;
                    set_to  = 1'b1;
                    set_be  = busErrorIn;
                end else if (busErrorIn) begin
                    state_d = ST_ERR_WAIT;
                    set_be  = 1'b1;
                end
            end
            ST_ERR_WAIT: begin
                if (endTransactionIn) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (timeout) begin
                    state_d = ST_IDLE;
                    set_to  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            burst_q <= '0;
            beat_q  <= '0;
            idle_q  <= 1'b1;
            done_q  <= 1'b0;
            mm_q    <= 1'b0;
            be_q    <= 1'b0;
            to_q    <= 1'b0;
            pe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            beat_q  <= beat_d;
            idle_q  <= (state_d == ST_IDLE);
            done_q  <= done_d;
            // a setting event in the same cycle beats clearErrors
            mm_q    <= (mm_q && !clearErrors) || set_mm;
            be_q    <= (be_q && !clearErrors) || set_be;
            to_q    <= (to_q && !clearErrors) || set_to;
            pe_q    <= (pe_q && !clearErrors) || set_pe;
        end
    end

    assign busIdle         = idle_q;
    assign transactionDone = done_q;
    assign beatCount       = beat_q;
    assign beatMismatch    = mm_q;
    assign busErrorSeen    = be_q;
    assign timeoutError    = to_q;
    assign protocolError   = pe_q;

endmodule
